// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, ALU op codes, flag bit positions,
// branch condition encodings and the execute->memory stage payload.
package cpu_pkg;

  localparam int unsigned DW  = 32;
  localparam int unsigned RW  = 5;
  localparam int unsigned OPW = 5;

  // Opcode map; ADD..XORI is a contiguous group.
  localparam logic [OPW-1:0] OP_ADD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ADDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_SUB   = 5'b00010;
  localparam logic [OPW-1:0] OP_SUBI  = 5'b00011;
  localparam logic [OPW-1:0] OP_CMP   = 5'b00100;
  localparam logic [OPW-1:0] OP_AND   = 5'b00101;
  localparam logic [OPW-1:0] OP_ANDI  = 5'b00110;
  localparam logic [OPW-1:0] OP_OR    = 5'b00111;
  localparam logic [OPW-1:0] OP_ORI   = 5'b01000;
  localparam logic [OPW-1:0] OP_XOR   = 5'b01001;
  localparam logic [OPW-1:0] OP_XORI  = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL   = 5'b01011;
  localparam logic [OPW-1:0] OP_DIV   = 5'b01100;
  localparam logic [OPW-1:0] OP_NOT   = 5'b01101;
  localparam logic [OPW-1:0] OP_MOVEH = 5'b01110;
  localparam logic [OPW-1:0] OP_MOVEL = 5'b01111;
  localparam logic [OPW-1:0] OP_LD    = 5'b10000;
  localparam logic [OPW-1:0] OP_ST    = 5'b10001;
  localparam logic [OPW-1:0] OP_CALL  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR    = 5'b10011;
  localparam logic [OPW-1:0] OP_RET   = 5'b10100;
  localparam logic [OPW-1:0] OP_RETI  = 5'b10101;

  // ALU operation codes used by alu_wrapper.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;
  localparam logic [2:0] ALU_DIV = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

  // Bit positions inside the 2-bit flag register.
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  // Branch condition encodings.
  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LT = 2'b10;
  localparam logic [1:0] BR_GT = 2'b11;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [DW-1:0]  result;
    logic [RW-1:0]  rd;
    logic [DW-1:0]  store_data;
    logic           reg_we;
    logic           mem_we;
    logic           mem_re;
  } stage_payload_t;

  // Resolve a branch condition against the current flag register.
  function automatic logic br_taken(input logic [1:0] flags, input logic [1:0] cond);
    logic z;
    logic n;
    z = flags[FLAG_Z];
    n = flags[FLAG_N];
    case (cond)
      BR_EQ:   br_taken = z;
      BR_NE:   br_taken = !z;
      BR_LT:   br_taken = n;
      default: br_taken = !z && !n;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Output register plus one skid entry with valid/ready on both sides.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake (in_ready = skid entry empty)
//   in_data               : upstream payload
//   out_valid/out_ready   : downstream handshake
//   out_data              : registered payload, stable while stalled
module skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push;
  logic         out_free;

  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;
  // Output register can take a new beat when empty or delivering this cycle.
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      // Skid entry is older than any new beat, so it drains first; push
      // cannot happen while the skid entry is occupied.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) begin
          out_data <= in_data;
        end
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline stage: registers ALU result and decoded
// enables, owns the Z/N flag register, and resolves conditional branches.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid/in_ready               : upstream handshake
//   in_opcode .. in_br_target       : beat from alu_wrapper
//   out_valid/out_ready             : downstream handshake
//   out_opcode .. out_mem_re        : registered payload and enables
//   flags_q                         : architectural flags {Z, N}
//   redirect/redirect_pc            : one-cycle taken-branch redirect
module ex_mem_stage
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_opcode,
  input  logic [DW-1:0]  in_result,
  input  logic [1:0]     in_flags,
  input  logic [RW-1:0]  in_rd,
  input  logic [DW-1:0]  in_store_data,
  input  logic [1:0]     in_br_cond,
  input  logic [DW-1:0]  in_br_target,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_opcode,
  output logic [DW-1:0]  out_result,
  output logic [RW-1:0]  out_rd,
  output logic [DW-1:0]  out_store_data,
  output logic           out_reg_we,
  output logic           out_mem_we,
  output logic           out_mem_re,
  output logic [1:0]     flags_q,
  output logic           redirect,
  output logic           redirect_pc_unused_guard,
  output logic [DW-1:0]  redirect_pc
);

  localparam int unsigned PW = $bits(stage_payload_t);

  stage_payload_t pl_in;
  stage_payload_t pl_out;
  logic           sb_in_ready;
  logic           keep;
  logic           flag_op;
  logic           br_fire;

  assign redirect_pc_unused_guard = 1'b0;

  // While redirecting, upstream beats are swallowed so the wrong path drains.
  assign in_ready = !rst && (sb_in_ready || redirect);
  assign keep     = in_valid && in_ready && !redirect;

  // Enable decode and flag-writer classification.
  always_comb begin
    pl_in            = '0;
    pl_in.opcode     = in_opcode;
    pl_in.result     = in_result;
    pl_in.rd         = in_rd;
    pl_in.store_data = in_store_data;
    pl_in.reg_we     = 1'b0;
    pl_in.mem_we     = 1'b0;
    pl_in.mem_re     = 1'b0;
    flag_op          = 1'b0;
    case (in_opcode)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
        pl_in.reg_we = 1'b1;
        flag_op      = 1'b1;
      end
      OP_CMP: flag_op = 1'b1;
      OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XOR, OP_XORI,
      OP_MUL, OP_DIV, OP_NOT, OP_MOVEH, OP_MOVEL: pl_in.reg_we = 1'b1;
      OP_LD: begin
        pl_in.reg_we = 1'b1;
        pl_in.mem_re = 1'b1;
      end
      OP_ST:   pl_in.mem_we = 1'b1;
      default: ;
    endcase
  end

  // Branch sees the flags before this beat's own (nonexistent) update.
  assign br_fire = keep && (in_opcode == OP_BR) && br_taken(flags_q, in_br_cond);

  // Flag register and redirect pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= 2'b00;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      if (keep && flag_op) begin
        flags_q <= in_flags;
      end
      redirect <= br_fire;
      if (br_fire) begin
        redirect_pc <= in_br_target;
      end
    end
  end

  skid_buffer #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (keep),
    .in_ready  (sb_in_ready),
    .in_data   (pl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  assign out_opcode     = pl_out.opcode;
  assign out_result     = pl_out.result;
  assign out_rd         = pl_out.rd;
  assign out_store_data = pl_out.store_data;
  assign out_reg_we     = pl_out.reg_we;
  assign out_mem_we     = pl_out.mem_we;
  assign out_mem_re     = pl_out.mem_re;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a FIFO-occupancy model of the stage
// checked every cycle, plus hand-computed directed expectations.
module tb_ex_mem_stage;
  import cpu_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [4:0]     in_opcode;
  logic [31:0]    in_result;
  logic [1:0]     in_flags;
  logic [4:0]     in_rd;
  logic [31:0]    in_store_data;
  logic [1:0]     in_br_cond;
  logic [31:0]    in_br_target;
  logic           out_valid;
  logic           out_ready;
  logic [4:0]     out_opcode;
  logic [31:0]    out_result;
  logic [4:0]     out_rd;
  logic [31:0]    out_store_data;
  logic           out_reg_we;
  logic           out_mem_we;
  logic           out_mem_re;
  logic [1:0]     flags_q;
  logic           redirect;
  logic           guard;
  logic [31:0]    redirect_pc;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .in_opcode                (in_opcode),
    .in_result                (in_result),
    .in_flags                 (in_flags),
    .in_rd                    (in_rd),
    .in_store_data            (in_store_data),
    .in_br_cond               (in_br_cond),
    .in_br_target             (in_br_target),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .out_opcode               (out_opcode),
    .out_result               (out_result),
    .out_rd                   (out_rd),
    .out_store_data           (out_store_data),
    .out_reg_we               (out_reg_we),
    .out_mem_we               (out_mem_we),
    .out_mem_re               (out_mem_re),
    .flags_q                  (flags_q),
    .redirect                 (redirect),
    .redirect_pc_unused_guard (guard),
    .redirect_pc              (redirect_pc)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] sd;
    logic        rwe;
    logic        mwe;
    logic        mre;
  } beat_t;

  beat_t       q[$];          // beats held by the stage, oldest first (max 2)
  logic [1:0]  m_flags;
  logic        m_redir;
  logic [31:0] m_pc;

  always @(posedge clk) begin
    beat_t      b;
    logic       rdy;
    logic       dlv;
    logic       z;
    logic       n;
    logic       tk;
    logic       nredir;
    logic [1:0] nflags;
    if (rst) begin
      q.delete();
      m_flags = 2'b00;
      m_redir = 1'b0;
    end else begin
      rdy    = (q.size() < 2) || m_redir;
      dlv    = (q.size() > 0) && out_ready;
      nredir = 1'b0;
      nflags = m_flags;
      if (in_valid && rdy && !m_redir) begin
        b.op  = in_opcode;
        b.res = in_result;
        b.rd  = in_rd;
        b.sd  = in_store_data;
        b.rwe = in_opcode inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_ANDI,
                                  OP_OR, OP_ORI, OP_XOR, OP_XORI, OP_MUL, OP_DIV,
                                  OP_NOT, OP_MOVEH, OP_MOVEL, OP_LD};
        b.mre = (in_opcode == OP_LD);
        b.mwe = (in_opcode == OP_ST);
        q.push_back(b);
        if (in_opcode inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_CMP}) nflags = in_flags;
        if (in_opcode == OP_BR) begin
          z = m_flags[1];
          n = m_flags[0];
          tk = (in_br_cond == 2'b00) ? z :
               (in_br_cond == 2'b01) ? !z :
               (in_br_cond == 2'b10) ? n : (!z && !n);
          nredir = tk;
          if (tk) m_pc = in_br_target;
        end
      end
      if (dlv) void'(q.pop_front());
      m_flags = nflags;
      m_redir = nredir;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_opcode", 32'(out_opcode), 32'(q[0].op));
        chk("out_result", out_result, q[0].res);
        chk("out_rd", 32'(out_rd), 32'(q[0].rd));
        chk("out_store_data", out_store_data, q[0].sd);
        chk("out_reg_we", 32'(out_reg_we), 32'(q[0].rwe));
        chk("out_mem_we", 32'(out_mem_we), 32'(q[0].mwe));
        chk("out_mem_re", 32'(out_mem_re), 32'(q[0].mre));
      end
      chk("flags_q", 32'(flags_q), 32'(m_flags));
      chk("redirect", 32'(redirect), 32'(m_redir));
      if (m_redir) chk("redirect_pc", redirect_pc, m_pc);
      chk("in_ready", 32'(in_ready), 32'(!rst && ((q.size() < 2) || m_redir)));
    end
  end

  // Delivered destination tags, in order.
  logic [4:0] delivered[$];
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) delivered.push_back(out_rd);
  end

  function automatic logic [31:0] dlv_at(input int i);
    return (i < delivered.size()) ? 32'(delivered[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic int count_rd(input logic [4:0] rd);
    int c = 0;
    foreach (delivered[i]) if (delivered[i] == rd) c++;
    return c;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [4:0] op, input logic [31:0] res, input logic [1:0] fl,
                          input logic [4:0] rd, input logic [31:0] sd, input logic [1:0] cond,
                          input logic [31:0] tgt);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_result     = res;
    in_flags      = fl;
    in_rd         = rd;
    in_store_data = sd;
    in_br_cond    = cond;
    in_br_target  = tgt;
  endtask

  // Present a beat until accepted (bounded); leaves in_valid asserted.
  task automatic offer(input logic [4:0] op, input logic [31:0] res, input logic [1:0] fl,
                       input logic [4:0] rd, input logic [31:0] sd, input logic [1:0] cond,
                       input logic [31:0] tgt);
    logic acc;
    int   k;
    set_beat(op, res, fl, rd, sd, cond, tgt);
    k = 0;
    do begin
      acc = in_ready;
      step();
      k++;
    end while (!acc && k < 50);
    chk("offer_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    set_beat(OP_ADD, '0, 2'b00, '0, '0, 2'b00, '0);
    in_valid = 1'b0;
    step();
    started = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_reg_we", 32'(out_reg_we), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ADD: one-cycle latency
    offer(OP_ADD, 32'h5, 2'b00, 5'd1, 32'h0, 2'b00, 32'h0);
    in_valid = 1'b0;
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_out_result", out_result, 32'h5);
    chk("add_out_reg_we", 32'(out_reg_we), 32'd1);
    chk("add_flags", 32'(flags_q), 32'd0);
    idle(1);

    // Taken branch: CMP sets Z, BR EQ taken, following ADD squashed
    offer(OP_CMP, 32'h0, 2'b10, 5'd2, 32'h0, 2'b00, 32'h0);
    offer(OP_BR, 32'h0, 2'b00, 5'd0, 32'h0, BR_EQ, 32'h40);
    set_beat(OP_ADD, 32'h7, 2'b01, 5'd3, 32'h0, 2'b00, 32'h0);
    chk("br_redirect", 32'(redirect), 32'd1);
    chk("br_redirect_pc", redirect_pc, 32'h40);
    chk("br_squash_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("br_redirect_one_cycle", 32'(redirect), 32'd0);
    chk("br_flags_kept", 32'(flags_q), 32'h2);
    idle(3);

    // Untaken branch: N set, GT not taken; then NE and LT taken
    offer(OP_CMP, 32'h0, 2'b01, 5'd2, 32'h0, 2'b00, 32'h0);
    offer(OP_BR, 32'h0, 2'b00, 5'd0, 32'h0, BR_GT, 32'h80);
    in_valid = 1'b0;
    chk("br_gt_untaken", 32'(redirect), 32'd0);
    chk("br_gt_flags", 32'(flags_q), 32'h1);
    offer(OP_BR, 32'h0, 2'b00, 5'd0, 32'h0, BR_NE, 32'h1234);
    in_valid = 1'b0;
    chk("br_ne_taken", 32'(redirect), 32'd1);
    chk("br_ne_pc", redirect_pc, 32'h1234);
    idle(1);
    offer(OP_BR, 32'h0, 2'b00, 5'd0, 32'h0, BR_LT, 32'h2000);
    in_valid = 1'b0;
    chk("br_lt_pc", redirect_pc, 32'h2000);
    idle(2);

    // Back-to-back mixed opcodes at full throughput
    offer(OP_LD, 32'h300, 2'b00, 5'd7, 32'h0, 2'b00, 32'h0);
    offer(OP_MUL, 32'h42, 2'b11, 5'd8, 32'h0, 2'b00, 32'h0);
    offer(OP_XORI, 32'hF0F0, 2'b00, 5'd9, 32'h0, 2'b00, 32'h0);
    offer(5'b11111, 32'h1, 2'b10, 5'd13, 32'h5, 2'b00, 32'h0);
    offer(OP_SUBI, 32'h0, 2'b10, 5'd14, 32'h0, 2'b00, 32'h0);
    offer(OP_RET, 32'h9, 2'b01, 5'd15, 32'h0, 2'b00, 32'h0);
    in_valid = 1'b0;
    chk("tput_flags_subi", 32'(flags_q), 32'h2);
    idle(3);

    // Stall: A in output register, B in skid, C waits
    out_ready = 1'b0;
    delivered.delete();
    offer(OP_LD, 32'hA0, 2'b00, 5'd10, 32'h0, 2'b00, 32'h0);
    offer(OP_MOVEL, 32'hB0, 2'b00, 5'd11, 32'h0, 2'b00, 32'h0);
    set_beat(OP_SUB, 32'hC0, 2'b00, 5'd12, 32'h0, 2'b00, 32'h0);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_head_rd", 32'(out_rd), 32'd10);
    step();
    chk("stall_in_ready_held", 32'(in_ready), 32'd0);
    chk("stall_head_result", out_result, 32'hA0);
    out_ready = 1'b1;
    offer(OP_SUB, 32'hC0, 2'b00, 5'd12, 32'h0, 2'b00, 32'h0);
    idle(3);
    chk("stall_count", 32'(delivered.size()), 32'd3);
    chk("stall_first", dlv_at(0), 32'd10);
    chk("stall_second", dlv_at(1), 32'd11);
    chk("stall_third", dlv_at(2), 32'd12);

    // Store
    offer(OP_ST, 32'h100, 2'b00, 5'd4, 32'hDEAD_BEEF, 2'b00, 32'h0);
    in_valid = 1'b0;
    chk("st_mem_we", 32'(out_mem_we), 32'd1);
    chk("st_reg_we", 32'(out_reg_we), 32'd0);
    chk("st_mem_re", 32'(out_mem_re), 32'd0);
    chk("st_store_data", out_store_data, 32'hDEAD_BEEF);
    chk("st_result", out_result, 32'h100);
    idle(2);

    // Reset with both entries full and flags = 11
    offer(OP_CMP, 32'h0, 2'b11, 5'd5, 32'h0, 2'b00, 32'h0);
    out_ready = 1'b0;
    offer(OP_AND, 32'h66, 2'b00, 5'd6, 32'h0, 2'b00, 32'h0);
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_flags", 32'(flags_q), 32'h3);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_pulse_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_pulse_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pulse_flags", 32'(flags_q), 32'd0);
    chk("rst_pulse_result", out_result, 32'd0);
    chk("rst_pulse_in_ready2", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(4);
    chk("rst_no_rd5", 32'(count_rd(5'd5)), 32'd0);
    chk("rst_no_rd6", 32'(count_rd(5'd6)), 32'd0);
    chk("squashed_never_out", 32'(count_rd(5'd3)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage directly downstream of `alu_wrapper`. It registers the ALU result and decoded control, holds the architectural 2-bit flag register, and resolves conditional branches against those flags. A valid/ready handshake with a one-entry skid buffer lets the memory stage stall without losing beats.

## Interface
- `DW`, 32: data/result/address width.
- `RW`, 5: destination register index width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage accepts the beat this cycle.
- `in_opcode` in 5: instruction opcode.
- `in_result` in DW: `alu_wrapper` output; for LD/ST this is the effective address.
- `in_flags` in 2: `alu_wrapper` flags, bit 1 = Z, bit 0 = N.
- `in_rd` in RW: destination register.
- `in_store_data` in DW: ST data.
- `in_br_cond` in 2: condition for BR. 00 EQ, 01 NE, 10 LT, 11 GT.
- `in_br_target` in DW: branch target PC.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_opcode` out 5, `out_result` out DW, `out_rd` out RW, `out_store_data` out DW: registered payload.
- `out_reg_we`, `out_mem_we`, `out_mem_re` out 1 each: decoded enables.
- `flags_q` out 2: architectural flag register.
- `redirect` out 1, `redirect_pc` out DW: taken-branch redirect to fetch; upstream squashes on it.

## Operation
- Accept = `in_valid && in_ready`. Deliver = `out_valid && out_ready`.
- Flag update on accept happens only for ADD, ADDI, SUB, SUBI, and CMP: `flags_q <= in_flags`. All other opcodes leave `flags_q` unchanged.
- Enable decode is registered with the payload:
  - `reg_we` = 1 for ADD…XORI except CMP, and for MUL, DIV, NOT, MOVEH, MOVEL, LD.
  - `mem_re` = 1 only for LD.
  - `mem_we` = 1 only for ST.
  - CMP, BR, CALL, RET, RETI, and unmapped opcodes: all enables 0, but the beat is still forwarded.
- Branch (BR = 5'b10011) on accept evaluates `flags_q` as it stands before this beat's own update (BR never updates flags):
  - EQ: Z.
  - NE: !Z.
  - LT: N.
  - GT: !Z && !N.
  - If taken, in the next cycle `redirect` = 1 and `redirect_pc` = `in_br_target`, for exactly one cycle.
- Squash: while `redirect` = 1, `in_ready` is forced to 1. Any beat accepted that cycle is discarded: not stored, no flag update, no branch evaluation.
- Buffering uses an output register plus a single skid entry, in FIFO order.
  - Accept while the output register is empty or delivering: the beat goes to the output register.
  - Accept while the output register is full and stalled: the beat goes to the skid entry.
  - On delivery with the skid entry full: skid moves to the output register and the skid entry empties.
- `in_ready` = `!skid_valid` (registered), except when forced to 1 by redirect.
- Stalls never drop or reorder beats. Payload is held stable while `out_valid && !out_ready`.

## Timing
- Latency: accept in cycle N → `out_valid` in N+1 when not stalled.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Redirect: taken BR accepted in N → `redirect` high in N+1 only.
- Flag visibility: CMP accepted in N updates `flags_q` at the N→N+1 edge. A BR accepted in N+1 sees the new flags.
- Reset (cycle asserted and every cycle held):
  - `out_valid`, `redirect`, `in_ready`, all enables, and `flags_q` = 0.
  - Payload outputs = 0.
  - Both buffer entries are invalidated mid-operation, with no partial delivery.
  - `in_ready` = 1 the first cycle after `rst` drops.
- Simultaneous accept and deliver with the skid empty: the output register reloads with the new beat and `out_valid` stays 1.

## Structure
- `cpu_pkg` holds:
  - the 5-bit opcode localparams, including BR;
  - the 3-bit ALU op codes;
  - `FLAG_Z` = 1 and `FLAG_N` = 0;
  - the branch condition encodings;
  - a `stage_payload_t` packed struct (opcode, result, rd, store_data, enables).
- One sub-module, `skid_buffer`, is parameterized on payload width and implements the output register plus skid entry with valid/ready. Flag logic, decode, and branch logic stay in `ex_mem_stage`.

## Test plan
- **ADD:** ADD, result 0x00000005, flags 00, `out_ready` = 1 → next cycle `out_valid` = 1, `out_result` = 0x5, `out_reg_we` = 1, `flags_q` = 00.
- **Taken branch:**
  - Stimulus: CMP with flags 10, then BR EQ with target 0x00000040, then ADD in the following cycle.
  - Required: `redirect` = 1 for one cycle with `redirect_pc` = 0x40; the ADD is discarded and never appears on out.
- **Untaken branch:** `flags_q` = 01, BR GT with target 0x80 → `redirect` stays 0.
- **Stall:**
  - Stimulus: `out_ready` = 0 while beats A, B, C are offered.
  - Required: A is held in the output register, B in skid, `in_ready` = 0 and C waits.
  - After `out_ready` = 1: delivery order is A, B, C with no loss.
- **Store:** ST, result 0x100, store_data 0xDEADBEEF → `out_mem_we` = 1, `out_reg_we` = 0, `out_store_data` = 0xDEADBEEF.
- **Reset with full buffer:**
  - Stimulus: `rst` pulsed with both entries full and `flags_q` = 11.
  - Required: next cycle `out_valid` = 0, `flags_q` = 00, `in_ready` = 0 during `rst` and 1 after release.
